// File: rtl/frame_update_sched.sv
// Per-frame game-logic scheduler: each qualifying VSYNC falling edge runs the
// four update stages in fixed order, one at a time, through start/done handshakes.
module frame_update_sched #(
  parameter int unsigned FRAME_DIV     = 1,
  parameter int unsigned STAGE_TIMEOUT = 12000
) (
  input  logic        pclk_i,
  input  logic        rst_n_i,
  input  logic        vs_i,
  input  logic        enable_i,
  input  logic        clr_err_i,
  input  logic [3:0]  done_i,
  output logic [3:0]  start_o,
  output logic        busy_o,
  output logic        update_done_o,
  output logic [1:0]  stage_idx_o,
  output logic [15:0] frame_cnt_o,
  output logic [3:0]  timeout_err_o,
  output logic        overrun_o,
  output logic [1:0]  state_o
);

  // Handshake: start_o[k] is a one-cycle request; the stage answers with done_i[k]
  // high for at least one cycle. done_i is only looked at while waiting on that
  // stage, so early, stray or other-stage done bits never advance the sequence.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [15:0] TMO_LAST = 16'(STAGE_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        vs_q;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  stage_q, stage_d;
  logic [3:0]  start_q, start_d;
  logic        busy_q, busy_d;
  logic        upd_q, upd_d;
  logic [15:0] frame_q, frame_d;
  logic [3:0]  terr_q, terr_d;
  logic        ovr_q, ovr_d;
  logic        trig;
  logic        advance;

  assign trig = vs_q & ~vs_i;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    timer_d   = timer_q;
    stage_d   = stage_q;
    frame_d   = frame_q;
    terr_d    = terr_q;
    ovr_d     = ovr_q;
    advance   = 1'b0;

    // Clearing first lets any error raised this cycle override the clear.
    if (clr_err_i) begin
      terr_d = '0;
      ovr_d  = 1'b0;
    end
    if (trig && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trig && enable_i) begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            stage_d   = 2'd0;
            state_d   = S_ISSUE;
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_i[stage_q]) begin
          advance = 1'b1;
        end else if (timer_q == TMO_LAST) begin
          terr_d[stage_q] = 1'b1;
          advance         = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
        if (advance) begin
          if (stage_q == 2'd3) begin
            state_d = S_FINISH;
          end else begin
            stage_d = stage_q + 2'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: begin
        frame_d = frame_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    start_d = (state_d == S_ISSUE) ? (4'b0001 << stage_d) : 4'b0000;
    busy_d  = (state_d != S_IDLE);
    upd_d   = (state_d == S_FINISH);
  end

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      vs_q      <= 1'b1;
      div_cnt_q <= '0;
      timer_q   <= '0;
      stage_q   <= '0;
      start_q   <= '0;
      busy_q    <= 1'b0;
      upd_q     <= 1'b0;
      frame_q   <= '0;
      terr_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_i;
      div_cnt_q <= div_cnt_d;
      timer_q   <= timer_d;
      stage_q   <= stage_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      upd_q     <= upd_d;
      frame_q   <= frame_d;
      terr_q    <= terr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign start_o       = start_q;
  assign busy_o        = busy_q;
  assign update_done_o = upd_q;
  assign stage_idx_o   = stage_q;
  assign frame_cnt_o   = frame_q;
  assign timeout_err_o = terr_q;
  assign overrun_o     = ovr_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_frame_update_sched.sv
// Bench for frame_update_sched: a cycle-schedule model derived from stage
// response delays predicts every output; a second instance covers frame division.
module tb_frame_update_sched;
  localparam int T = 16;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic        enable = 1'b1;
  logic        clr_err = 1'b0;
  logic [3:0]  done = 4'd0;
  logic [3:0]  done_b = 4'hF;

  logic [3:0]  start, start_b;
  logic        busy, busy_b, upd, upd_b, ovr, ovr_b;
  logic [1:0]  stage, stage_b, st, st_b;
  logic [15:0] fcnt, fcnt_b;
  logic [3:0]  terr, terr_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_frame = 16'd0;
  logic [3:0]  exp_err = 4'd0;
  logic        exp_ovr = 1'b0;
  logic [23:0] exp_q[$];

  always #5 pclk = ~pclk;

  frame_update_sched #(.FRAME_DIV(1), .STAGE_TIMEOUT(T)) u_dut (
    .pclk_i(pclk), .rst_n_i(rst_n), .vs_i(vs), .enable_i(enable), .clr_err_i(clr_err),
    .done_i(done), .start_o(start), .busy_o(busy), .update_done_o(upd),
    .stage_idx_o(stage), .frame_cnt_o(fcnt), .timeout_err_o(terr), .overrun_o(ovr),
    .state_o(st)
  );

  frame_update_sched #(.FRAME_DIV(3), .STAGE_TIMEOUT(T)) u_div (
    .pclk_i(pclk), .rst_n_i(rst_n), .vs_i(vs), .enable_i(enable), .clr_err_i(clr_err),
    .done_i(done_b), .start_o(start_b), .busy_o(busy_b), .update_done_o(upd_b),
    .stage_idx_o(stage_b), .frame_cnt_o(fcnt_b), .timeout_err_o(terr_b), .overrun_o(ovr_b),
    .state_o(st_b)
  );

  // One full sequence. d_k is how many cycles after start[k] the stage pulses
  // done[k]; d_k > T means it never answers. Offsets are cycles after start[0].
  task automatic run_seq(input int d0, input int d1, input int d2, input int d3,
                         input int inj_off, input int en_off, input int clr_off,
                         input bit noise);
    int dd[4];
    int s[5];
    int fin;
    logic [3:0]  e_start, dn, e_err;
    logic        e_busy, e_upd, e_ovr;
    logic [1:0]  e_stage;
    logic [15:0] e_frame;
    logic [23:0] got_v, exp_v;
    dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
    s[0] = 0;
    for (int k = 0; k < 4; k++) s[k+1] = s[k] + ((dd[k] > T) ? T : dd[k]) + 1;
    fin = s[4];
    if (inj_off > fin) inj_off = -1;
    if (clr_off > fin + 3) clr_off = -1;

    exp_q.delete();
    for (int r = 0; r <= fin + 3; r++) begin
      e_start = 4'd0;
      e_busy  = (r <= fin);
      e_upd   = (r == fin);
      e_stage = 2'd3;
      e_frame = (r > fin) ? exp_frame + 16'd1 : exp_frame;
      for (int k = 0; k < 4; k++) begin
        if (r >= s[k] && r < s[k+1]) begin
          e_stage = 2'(k);
          if (r == s[k]) e_start = 4'(1 << k);
        end
      end
      exp_q.push_back({e_start, e_busy, e_upd, e_stage, e_frame});
    end

    @(negedge pclk);
    vs = 1'b0; enable = 1'b1; clr_err = 1'b0; done = 4'd0;
    for (int r = 0; r <= fin + 3; r++) begin
      @(negedge pclk);
      got_v = {start, busy, upd, stage, fcnt};
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL seq_cycle r=%0d got start=%b busy=%b upd=%b stage=%0d frame=%0d expected start=%b busy=%b upd=%b stage=%0d frame=%0d",
                 r, got_v[23:20], got_v[19], got_v[18], got_v[17:16], got_v[15:0],
                 exp_v[23:20], exp_v[19], exp_v[18], exp_v[17:16], exp_v[15:0]);
      end
      vs      = (r == inj_off) ? 1'b0 : 1'b1;
      enable  = (en_off >= 0 && r >= en_off) ? 1'b0 : 1'b1;
      clr_err = (r == clr_off);
      dn = noise ? 4'($urandom_range(0, 15)) : 4'd0;
      for (int k = 0; k < 4; k++) begin
        if (r > s[k] && r < s[k+1]) dn[k] = (dd[k] <= T) && (r == s[k] + dd[k]);
      end
      done = dn;
    end

    e_err = (clr_off >= 0) ? 4'd0 : exp_err;
    for (int k = 0; k < 4; k++) begin
      if (dd[k] > T && !(clr_off > s[k] + T)) e_err[k] = 1'b1;
    end
    e_ovr = (clr_off >= 0) ? 1'b0 : exp_ovr;
    if (inj_off >= 0 && !(clr_off > inj_off)) e_ovr = 1'b1;

    @(negedge pclk);
    vs = 1'b1; enable = 1'b1; clr_err = 1'b0; done = 4'd0;
    checks++;
    if (terr !== e_err) begin
      errors++;
      $display("FAIL seq_timeout_err got %b expected %b", terr, e_err);
    end
    checks++;
    if (ovr !== e_ovr) begin
      errors++;
      $display("FAIL seq_overrun got %b expected %b", ovr, e_ovr);
    end
    exp_err   = e_err;
    exp_ovr   = e_ovr;
    exp_frame = exp_frame + 16'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge pclk);
    checks++;
    if ({start, busy, upd, stage} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl got start=%b busy=%b upd=%b stage=%0d expected all 0", start, busy, upd, stage);
    end
    checks++;
    if (fcnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt got %0d expected 0", fcnt);
    end
    checks++;
    if ({terr, ovr} !== 5'd0) begin
      errors++;
      $display("FAIL reset_errors got terr=%b ovr=%b expected 0", terr, ovr);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge pclk);
      checks++;
      if (start !== 4'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle got start=%b busy=%b expected 0", start, busy);
      end
    end
    exp_frame = 16'd0; exp_err = 4'd0; exp_ovr = 1'b0;
  endtask

  task automatic test_nominal();
    run_seq(3, 3, 3, 3, -1, -1, -1, 1'b0);
    checks++;
    if (fcnt !== 16'd1) begin
      errors++;
      $display("FAIL nominal_frame1 got %0d expected 1", fcnt);
    end
    repeat (4) @(negedge pclk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_busy_gap got %b expected 0", busy);
    end
    run_seq(3, 3, 3, 3, -1, -1, -1, 1'b0);
    checks++;
    if (fcnt !== 16'd2) begin
      errors++;
      $display("FAIL nominal_frame2 got %0d expected 2", fcnt);
    end
  endtask

  task automatic test_timeout();
    // Stage 2 silent; clr_err lands on the very cycle the error sets.
    run_seq(3, 3, 99, 3, -1, -1, 8 + T, 1'b0);
    checks++;
    if (terr !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_stage2 got %b expected 0100", terr);
    end
    @(negedge pclk); clr_err = 1'b1;
    @(negedge pclk); clr_err = 1'b0;
    checks++;
    if (terr !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_clear got %b expected 0000", terr);
    end
    exp_err = 4'd0; exp_ovr = 1'b0;
    run_seq(2, T, 1, T, -1, -1, -1, 1'b0);
  endtask

  task automatic test_overrun();
    run_seq(3, 8, 3, 3, 6, -1, -1, 1'b0);
    repeat (20) begin
      @(negedge pclk);
      checks++;
      if (start !== 4'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL overrun_no_extra got start=%b busy=%b expected 0", start, busy);
      end
    end
    clr_err = 1'b1;
    @(negedge pclk); clr_err = 1'b0;
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b expected 0", ovr);
    end
    exp_ovr = 1'b0; exp_err = 4'd0;
  endtask

  task automatic test_enable();
    int n_start;
    n_start = 0;
    @(negedge pclk); enable = 1'b0; vs = 1'b0;
    @(negedge pclk); vs = 1'b1;
    repeat (30) begin
      @(negedge pclk);
      if (start !== 4'd0) n_start++;
    end
    checks++;
    if (n_start !== 0 || fcnt !== exp_frame) begin
      errors++;
      $display("FAIL enable_low got starts=%0d frame=%0d expected starts=0 frame=%0d", n_start, fcnt, exp_frame);
    end
    enable = 1'b1;
    run_seq(3, 4, 2, 5, -1, 2, -1, 1'b0);
  endtask

  task automatic test_random();
    int d[4];
    int inj, clr, en;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) begin
        d[k] = $urandom_range(1, T + 3);
        if ($urandom_range(0, 5) == 0) d[k] = T;
      end
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
      clr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
      en  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_seq(d[0], d[1], d[2], d[3], inj, en, clr, 1'b1);
      repeat ($urandom_range(0, 6)) @(negedge pclk);
    end
  endtask

  task automatic test_div();
    bit en_pat[11];
    int q, n_upd, n_start;
    bit e_seq;
    en_pat = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
    q = 0;
    @(negedge pclk); rst_n = 1'b0;
    @(negedge pclk); rst_n = 1'b1; done = 4'hF;
    for (int ev = 0; ev < 11; ev++) begin
      @(negedge pclk); enable = en_pat[ev]; vs = 1'b0;
      n_upd = 0; n_start = 0;
      for (int r = 0; r < 20; r++) begin
        @(negedge pclk);
        if (r == 0) vs = 1'b1;
        if (upd_b === 1'b1) n_upd++;
        if (start_b !== 4'd0) n_start++;
      end
      e_seq = 1'b0;
      if (en_pat[ev]) begin
        q++;
        e_seq = (q % 3 == 0);
      end
      checks++;
      if (n_upd != int'(e_seq) || n_start != (e_seq ? 4 : 0)) begin
        errors++;
        $display("FAIL div_event%0d got update_done=%0d starts=%0d expected %0d and %0d",
                 ev, n_upd, n_start, int'(e_seq), e_seq ? 4 : 0);
      end
    end
    enable = 1'b1;
    checks++;
    if (fcnt_b !== 16'd3) begin
      errors++;
      $display("FAIL div_frame_cnt got %0d expected 3", fcnt_b);
    end
    done = 4'd0;
    @(negedge pclk); rst_n = 1'b0;
    @(negedge pclk); rst_n = 1'b1;
    exp_frame = 16'd0; exp_err = 4'd0; exp_ovr = 1'b0;
  endtask

  task automatic test_reset_mid();
    run_seq(3, 3, 99, 3, -1, -1, -1, 1'b0);
    done = 4'b0011;
    @(negedge pclk); vs = 1'b0;
    for (int r = 0; r < 7; r++) begin
      @(negedge pclk);
      vs = 1'b1;
      if (r == 4) begin
        checks++;
        if (start !== 4'b0100) begin
          errors++;
          $display("FAIL reset_mid_reach got start=%b expected 0100", start);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({start, busy, upd, stage, fcnt} !== 24'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got start=%b busy=%b upd=%b stage=%0d frame=%0d expected 0",
               start, busy, upd, stage, fcnt);
    end
    checks++;
    if ({terr, ovr} !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_errors got terr=%b ovr=%b expected 0", terr, ovr);
    end
    @(negedge pclk); rst_n = 1'b1;
    repeat (20) begin
      @(negedge pclk);
      done = 4'($urandom_range(0, 15));
      checks++;
      if (start !== 4'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_start got start=%b busy=%b expected 0", start, busy);
      end
    end
    done = 4'd0;
    exp_frame = 16'd0; exp_err = 4'd0; exp_ovr = 1'b0;
    run_seq(1, 2, 3, 4, -1, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_overrun();
    test_enable();
    test_random();
    test_div();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
